// File: rtl/board_pkg.sv
// Board-wide constants shared by every project on this board.
// Debounce defaults are derived from the clock so retiming the board keeps the 10 ms window.
package board_pkg;

    localparam int CLK_FREQ_HZ            = 25_000_000;
    localparam int DEBOUNCE_MS            = 10;
    localparam int DEBOUNCE_LIMIT_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int NUM_SWITCHES           = 4;
    localparam int NUM_LEDS               = 4;

endpackage : board_pkg

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchroniser, stability counter, stable level and edge strobes.
// A new level is accepted only after DEBOUNCE_LIMIT uninterrupted cycles of disagreement.
module debounce_channel
    import board_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int              CW       = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_rise;
    logic          r_fall;

    logic [CW-1:0] w_cnt_next;
    logic          w_stable_next;
    logic          w_rise_next;
    logic          w_fall_next;

    // Filter decision from pre-edge state; any return to the stable level discards progress.
    always_comb begin
        w_cnt_next    = '0;
        w_stable_next = r_stable;
        w_rise_next   = 1'b0;
        w_fall_next   = 1'b0;
        if (r_sync2 == r_stable) begin
            w_cnt_next = '0;
        end else if (r_cnt != CNT_LAST) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end else begin
            w_cnt_next    = '0;
            w_stable_next = r_sync2;
            w_rise_next   = r_sync2;
            w_fall_next   = ~r_sync2;
        end
    end

    // Synchroniser, counter, stable level and strobes, all cleared asynchronously.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync1  <= i_Switch;
            r_sync2  <= r_sync1;
            r_cnt    <= w_cnt_next;
            r_stable <= w_stable_next;
            r_rise   <= w_rise_next;
            r_fall   <= w_fall_next;
        end
    end

    assign o_Switch = r_stable;
    assign o_Rise   = r_rise;
    assign o_Fall   = r_fall;

endmodule : debounce_channel

// File: rtl/switch_debounce.sv
// Multi-channel switch conditioner: independent debounce_channel per board switch.
module switch_debounce #(
    parameter int NUM_SWITCHES   = board_pkg::NUM_SWITCHES,
    parameter int DEBOUNCE_LIMIT = board_pkg::DEBOUNCE_LIMIT_DEFAULT
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic [NUM_SWITCHES-1:0] o_Rise,
    output logic [NUM_SWITCHES-1:0] o_Fall
);

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
        ) u_chan (
            .i_Clk    (i_Clk),
            .i_Rst_L  (i_Rst_L),
            .i_Switch (i_Switch[g]),
            .o_Switch (o_Switch[g]),
            .o_Rise   (o_Rise[g]),
            .o_Fall   (o_Fall[g])
        );
    end

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_LIMIT=4; expected values are hand-derived.
module tb_switch_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] o_sw;
    logic [3:0] o_rise;
    logic [3:0] o_fall;

    int n_cmp  = 0;
    int n_miss = 0;
    int rise_cnt;

    switch_debounce #(
        .NUM_SWITCHES   (4),
        .DEBOUNCE_LIMIT (4)
    ) dut (
        .i_Clk    (clk),
        .i_Rst_L  (rst_n),
        .i_Switch (sw),
        .o_Switch (o_sw),
        .o_Rise   (o_rise),
        .o_Fall   (o_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_sw,
                             input logic [3:0] e_rise, input logic [3:0] e_fall);
        check({tag, ".sw"},   o_sw,   e_sw);
        check({tag, ".rise"}, o_rise, e_rise);
        check({tag, ".fall"}, o_fall, e_fall);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. reset held with all switches high
        rst_n = 1'b0;
        sw    = 4'b1111;
        #2;
        check_all("rst_hold0", 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_all("rst_hold", 4'b0000, 4'b0000, 4'b0000);
        end

        // 2. clean press on channel 0
        sw    = 4'b0001;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_all("press_wait", 4'b0000, 4'b0000, 4'b0000);
        end
        tick();
        check_all("press_e5", 4'b0001, 4'b0001, 4'b0000);
        tick();
        check_all("press_after", 4'b0001, 4'b0000, 4'b0000);

        // 3. three-cycle glitch on channel 1
        sw = 4'b0011;
        for (int k = 0; k < 3; k++) tick();
        sw = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_all("glitch", 4'b0001, 4'b0000, 4'b0000);
        end

        // 4. bounce on channel 2, then hold high
        rise_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            sw[2] = (b % 2 == 0) ? 1'b1 : 1'b0;
            for (int k = 0; k < 2; k++) begin
                tick();
                check("bounce_sw", o_sw, 4'b0001);
                if (o_rise[2]) rise_cnt++;
            end
        end
        sw[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bounce_wait", o_sw, 4'b0001);
            if (o_rise[2]) rise_cnt++;
        end
        tick();
        check_all("bounce_e5", 4'b0101, 4'b0100, 4'b0000);
        if (o_rise[2]) rise_cnt++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (o_rise[2]) rise_cnt++;
        end
        check("bounce_rise_cnt", 4'(rise_cnt), 4'd1);

        // 5. channel 3 up, then release
        sw[3] = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("rel_setup", o_sw, 4'b1101);
        sw[3]    = 1'b0;
        rise_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_all("rel_wait", 4'b1101, 4'b0000, 4'b0000);
        end
        tick();
        check_all("rel_e5", 4'b0101, 4'b0000, 4'b1000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all("rel_after", 4'b0101, 4'b0000, 4'b0000);
        end

        // 1b. asynchronous reset between edges clears outputs before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 4'b0000, 4'b0000);
        sw = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();

        // 6. reset in the middle of a count on channel 0
        sw = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_all("mid_pre", 4'b0000, 4'b0000, 4'b0000);
        end
        rst_n = 1'b0;
        #1;
        check_all("mid_rst", 4'b0000, 4'b0000, 4'b0000);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_all("mid_wait", 4'b0000, 4'b0000, 4'b0000);
        end
        tick();
        check_all("mid_e5", 4'b0001, 4'b0001, 4'b0000);
        tick();
        check_all("mid_after", 4'b0001, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
        $finish;
    end

endmodule : tb_switch_debounce
